// File: rtl/my_verif_params_pkg.sv
// my_verif_params_pkg: shared AXI4-Lite widths, response codes and register word geometry.
package my_verif_params_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int REG_BYTES = 4;
    localparam int REG_IDX_SHIFT = 2;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi4_resp_t;
endpackage

// File: rtl/my_axi4_lite_reg_addr_dec.sv
// my_axi4_lite_reg_addr_dec: maps a byte address to a register index and the AXI response it earns.
module my_axi4_lite_reg_addr_dec
    import my_verif_params_pkg::*;
#(
    parameter int N_REGS = 8
) (
    input  logic [AXI_ADDR_W-1:0]     addr,
    input  logic                      is_wr,
    output logic [$clog2(N_REGS)-1:0] idx,
    output axi4_resp_t                resp
);
    localparam int IDX_W = $clog2(N_REGS);
    localparam int TOP = REG_IDX_SHIFT + IDX_W;
    logic unused_lsb;
    assign unused_lsb = ^addr[REG_IDX_SHIFT-1:0];
    assign idx = addr[REG_IDX_SHIFT +: IDX_W];
    // Any bit above the index field set means the address is past the last register.
    assign resp = (|addr[AXI_ADDR_W-1:TOP]) ? RESP_DECERR :
                  (is_wr && idx == '0)      ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: rtl/my_axi4_lite_reg_slv.sv
// my_axi4_lite_reg_slv: AXI4-Lite responder register file; reg 0 is a read-only ID, the rest are byte-strobed R/W.
// Defining MY_AXI4_LITE_REG_SLV_WR_PULSE_EN adds o_wr_pulse, a one-cycle per-register strobe on each OKAY write.
module my_axi4_lite_reg_slv
    import my_verif_params_pkg::*;
#(
    parameter int                    N_REGS   = 8,
    parameter logic [AXI_DATA_W-1:0] ID_VALUE = 32'h0001_0000
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic [AXI_ADDR_W-1:0]        i_awaddr,
    input  logic [2:0]                   i_awprot,
    input  logic                         i_awvalid,
    output logic                         o_awready,
    input  logic [AXI_DATA_W-1:0]        i_wdata,
    input  logic [REG_BYTES-1:0]         i_wstrb,
    input  logic                         i_wvalid,
    output logic                         o_wready,
    output axi4_resp_t                   o_bresp,
    output logic                         o_bvalid,
    input  logic                         i_bready,
    input  logic [AXI_ADDR_W-1:0]        i_araddr,
    input  logic [2:0]                   i_arprot,
    input  logic                         i_arvalid,
    output logic                         o_arready,
    output logic [AXI_DATA_W-1:0]        o_rdata,
    output axi4_resp_t                   o_rresp,
    output logic                         o_rvalid,
    input  logic                         i_rready,
    output logic [AXI_DATA_W*N_REGS-1:0] o_regs
`ifdef MY_AXI4_LITE_REG_SLV_WR_PULSE_EN
    ,
    output logic [N_REGS-1:0]            o_wr_pulse
`endif
);
    localparam int IDX_W = $clog2(N_REGS);
    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    w_state_t w_state;
    r_state_t r_state;
    logic aw_full, w_full, r_pend;
    logic [AXI_ADDR_W-1:0] aw_addr, ar_addr;
    logic [AXI_DATA_W-1:0] w_data;
    logic [REG_BYTES-1:0] w_strb;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    axi4_resp_t wr_resp, rd_resp;
    logic [N_REGS-1:0][AXI_DATA_W-1:0] reg_q;
    logic aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic unused_prot;
    assign unused_prot = ^{i_awprot, i_arprot};
    assign aw_hs = i_awvalid & o_awready;
    assign w_hs = i_wvalid & o_wready;
    assign ar_hs = i_arvalid & o_arready;
    assign commit = aw_full & w_full;
    assign wr_ok = commit && wr_resp == RESP_OKAY;
    assign o_regs = reg_q;
    my_axi4_lite_reg_addr_dec #(.N_REGS(N_REGS)) u_aw_dec (
        .addr(aw_addr), .is_wr(1'b1), .idx(wr_idx), .resp(wr_resp)
    );
    my_axi4_lite_reg_addr_dec #(.N_REGS(N_REGS)) u_ar_dec (
        .addr(ar_addr), .is_wr(1'b0), .idx(rd_idx), .resp(rd_resp)
    );
    // Holders fill independently; the write commits on the edge after both are full.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            w_state   <= W_IDLE;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_bvalid  <= 1'b0;
            o_bresp   <= RESP_OKAY;
        end else if (w_state == W_RESP) begin
            if (i_bready) begin
                w_state   <= W_IDLE;
                o_bvalid  <= 1'b0;
                o_awready <= 1'b1;
                o_wready  <= 1'b1;
            end
        end else if (commit) begin
            w_state  <= W_RESP;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            o_bvalid <= 1'b1;
            o_bresp  <= wr_resp;
        end else begin
            if (aw_hs) aw_addr <= i_awaddr;
            if (w_hs) begin
                w_data <= i_wdata;
                w_strb <= i_wstrb;
            end
            aw_full   <= aw_full | aw_hs;
            w_full    <= w_full | w_hs;
            o_awready <= ~(aw_full | aw_hs);
            o_wready  <= ~(w_full | w_hs);
            w_state   <= (aw_full | aw_hs | w_full | w_hs) ? W_COLLECT : W_IDLE;
        end
    end
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state   <= R_IDLE;
            r_pend    <= 1'b0;
            ar_addr   <= '0;
            o_arready <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rdata   <= '0;
            o_rresp   <= RESP_OKAY;
        end else if (r_state == R_IDLE) begin
            o_arready <= ~ar_hs;
            if (ar_hs) begin
                ar_addr <= i_araddr;
                r_state <= R_RESP;
                r_pend  <= 1'b1;
            end
        end else if (r_pend) begin
            r_pend   <= 1'b0;
            o_rvalid <= 1'b1;
            o_rresp  <= rd_resp;
            o_rdata  <= (rd_resp == RESP_OKAY) ? reg_q[rd_idx] : '0;
        end else if (i_rready) begin
            r_state   <= R_IDLE;
            o_rvalid  <= 1'b0;
            o_arready <= 1'b1;
        end
    end
    // Slot 0 holds the ID constant; the decoder never lets a write reach it.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) reg_q <= {{((N_REGS-1)*AXI_DATA_W){1'b0}}, ID_VALUE};
        else if (wr_ok)
            for (int b = 0; b < REG_BYTES; b++)
                if (w_strb[b]) reg_q[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
`ifdef MY_AXI4_LITE_REG_SLV_WR_PULSE_EN
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) o_wr_pulse <= '0;
        else o_wr_pulse <= wr_ok ? {{(N_REGS-1){1'b0}}, 1'b1} << wr_idx : '0;
    end
`endif
endmodule

// File: tb/tb_my_axi4_lite_reg_slv.sv
// tb_my_axi4_lite_reg_slv: directed and random AXI4-Lite traffic checked against a word-array model.
module tb_my_axi4_lite_reg_slv;
    localparam int N = 8;
    localparam logic [31:0] ID = 32'h0001_0000;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    logic i_clk = 1'b0, i_arst_n = 1'b1;
    logic [31:0] i_awaddr = '0, i_wdata = '0, i_araddr = '0;
    logic [2:0] i_awprot = '0, i_arprot = '0;
    logic [3:0] i_wstrb = '0;
    logic i_awvalid = 0, i_wvalid = 0, i_bready = 0, i_arvalid = 0, i_rready = 0;
    logic o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0] o_bresp, o_rresp;
    logic [31:0] o_rdata;
    logic [32*N-1:0] o_regs;
`ifdef MY_AXI4_LITE_REG_SLV_WR_PULSE_EN
    logic [N-1:0] o_wr_pulse;
`endif
    int n_vec = 0, n_err = 0;
    logic [31:0] model [N];

    my_axi4_lite_reg_slv #(.N_REGS(N), .ID_VALUE(ID)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n),
        .i_awaddr(i_awaddr), .i_awprot(i_awprot), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arprot(i_arprot), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_regs(o_regs)
`ifdef MY_AXI4_LITE_REG_SLV_WR_PULSE_EN
        , .o_wr_pulse(o_wr_pulse)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input bit wr);
        if (a >= 32'(4 * N)) return DECERR;
        if (wr && a < 32'd4) return SLVERR;
        return OKAY;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    task automatic model_reset();
        model[0] = ID;
        for (int k = 1; k < N; k++) model[k] = '0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (exp_resp(a, 1) == OKAY)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic check_regs();
        for (int k = 0; k < N; k++) check($sformatf("reg%0d", k), o_regs[32*k +: 32], model[k]);
    endtask

    task automatic send_aw(input logic [31:0] a, input int dly);
        int t = 0;
        repeat (dly) @(negedge i_clk);
        i_awaddr = a;
        i_awvalid = 1;
        while (!o_awready && t < 50) begin @(negedge i_clk); t++; end
        if (t == 50) check("aw_timeout", o_awready, 1);
        @(negedge i_clk);
        i_awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int t = 0;
        repeat (dly) @(negedge i_clk);
        i_wdata = d;
        i_wstrb = s;
        i_wvalid = 1;
        while (!o_wready && t < 50) begin @(negedge i_clk); t++; end
        if (t == 50) check("w_timeout", o_wready, 1);
        @(negedge i_clk);
        i_wvalid = 0;
    endtask

    task automatic send_ar(input logic [31:0] a, input int dly);
        int t = 0;
        repeat (dly) @(negedge i_clk);
        i_araddr = a;
        i_arvalid = 1;
        while (!o_arready && t < 50) begin @(negedge i_clk); t++; end
        if (t == 50) check("ar_timeout", o_arready, 1);
        @(negedge i_clk);
        i_arvalid = 0;
    endtask

    task automatic wait_b(input int stall, output logic [1:0] r);
        int t = 0;
        while (!o_bvalid && t < 50) begin @(negedge i_clk); t++; end
        if (t == 50) check("b_timeout", o_bvalid, 1);
        repeat (stall) @(negedge i_clk);
        r = o_bresp;
        i_bready = 1;
        @(negedge i_clk);
        i_bready = 0;
    endtask

    task automatic wait_r(input int stall, output logic [31:0] d, output logic [1:0] r);
        int t = 0;
        while (!o_rvalid && t < 50) begin @(negedge i_clk); t++; end
        if (t == 50) check("r_timeout", o_rvalid, 1);
        repeat (stall) @(negedge i_clk);
        d = o_rdata;
        r = o_rresp;
        i_rready = 1;
        @(negedge i_clk);
        i_rready = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int stall);
        logic [1:0] r;
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        wait_b(stall, r);
        check("bresp", r, exp_resp(a, 1));
        model_write(a, d, s);
        check_regs();
    endtask

    task automatic do_read(input logic [31:0] a, input int dly, input int stall);
        logic [31:0] d;
        logic [1:0] r;
        send_ar(a, dly);
        wait_r(stall, d, r);
        check("rresp", r, exp_resp(a, 0));
        check("rdata", d, exp_resp(a, 0) == OKAY ? model[widx(a)] : 32'h0);
    endtask

`ifdef MY_AXI4_LITE_REG_SLV_WR_PULSE_EN
    task automatic pulse_write(input logic [31:0] a, input logic [31:0] d, input logic [N-1:0] exp);
        logic [1:0] r;
        i_awaddr = a;
        i_wdata = d;
        i_wstrb = 4'hF;
        i_awvalid = 1;
        i_wvalid = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge i_clk);
            if (i == 1) begin i_awvalid = 0; i_wvalid = 0; end
            check($sformatf("pulse_c%0d", i), o_wr_pulse, i == 2 ? exp : '0);
        end
        wait_b(0, r);
        check("pulse_bresp", r, exp_resp(a, 1));
        model_write(a, d, 4'hF);
    endtask
`endif

    initial begin
        logic [31:0] a, old;
        logic [31:0] d;
        logic [1:0] r;
        int t;
        model_reset();
        #1 i_arst_n = 0;
        #2;
        check("rst_awready", o_awready, 0);
        check("rst_wready", o_wready, 0);
        check("rst_arready", o_arready, 0);
        check("rst_bvalid", o_bvalid, 0);
        check("rst_rvalid", o_rvalid, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_bresp", o_bresp, OKAY);
        check("rst_rresp", o_rresp, OKAY);
        check_regs();
        repeat (2) @(negedge i_clk);
        i_arst_n = 1;
        check("rel_awready_low", o_awready, 0);
        @(negedge i_clk);
        check("rel_awready", o_awready, 1);
        check("rel_wready", o_wready, 1);
        check("rel_arready", o_arready, 1);

        // AW and W together: B appears after the second edge.
        i_awaddr = 32'h4;
        i_wdata = 32'hDEAD_BEEF;
        i_wstrb = 4'hF;
        i_awvalid = 1;
        i_wvalid = 1;
        @(negedge i_clk);
        i_awvalid = 0;
        i_wvalid = 0;
        check("t1_bvalid_e0", o_bvalid, 0);
        check("t1_awready_e0", o_awready, 0);
        @(negedge i_clk);
        check("t1_bvalid_e1", o_bvalid, 1);
        check("t1_bresp", o_bresp, OKAY);
        check("t1_reg1", o_regs[63:32], 32'hDEAD_BEEF);
        i_bready = 1;
        @(negedge i_clk);
        i_bready = 0;
        check("t1_awready_back", o_awready, 1);
        model_write(32'h4, 32'hDEAD_BEEF, 4'hF);
        do_read(32'h4, 0, 0);

        // W leads AW by three cycles, partial strobes.
        do_write(32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(32'h8, 32'h1234_5678, 4'h5, 3, 0, 0);
        check("t2_reg2", o_regs[95:64], 32'hFF34_FF78);

        do_write(32'h0, 32'h5555_AAAA, 4'hF, 0, 0, 0);
        do_read(32'h0, 0, 0);
        do_read(32'h20, 0, 0);

        // B backpressure with a second AW waiting.
        fork
            send_aw(32'hC, 0);
            send_w(32'hA5A5_0F0F, 4'hF, 0);
        join
        t = 0;
        while (!o_bvalid && t < 50) begin @(negedge i_clk); t++; end
        i_awaddr = 32'h10;
        i_awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("bp_bvalid", o_bvalid, 1);
            check("bp_bresp", o_bresp, OKAY);
            check("bp_awready", o_awready, 0);
            check("bp_wready", o_wready, 0);
        end
        i_bready = 1;
        @(negedge i_clk);
        i_bready = 0;
        check("bp_awready_after_b", o_awready, 1);
        model_write(32'hC, 32'hA5A5_0F0F, 4'hF);
        @(negedge i_clk);
        i_awvalid = 0;
        send_w(32'h0BAD_F00D, 4'hF, 0);
        wait_b(0, r);
        check("bp2_bresp", r, OKAY);
        model_write(32'h10, 32'h0BAD_F00D, 4'hF);
        check_regs();

        // R backpressure.
        send_ar(32'hC, 0);
        t = 0;
        while (!o_rvalid && t < 50) begin @(negedge i_clk); t++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("rbp_rvalid", o_rvalid, 1);
            check("rbp_rdata", o_rdata, model[3]);
            check("rbp_rresp", o_rresp, OKAY);
            check("rbp_arready", o_arready, 0);
        end
        i_rready = 1;
        @(negedge i_clk);
        i_rready = 0;
        check("rbp_arready_back", o_arready, 1);

        // Read and write of the same register on the same edge: read sees the old word.
        old = model[3];
        i_awaddr = 32'hC;
        i_wdata = 32'h7777_1111;
        i_wstrb = 4'hF;
        i_araddr = 32'hC;
        i_awvalid = 1;
        i_wvalid = 1;
        i_arvalid = 1;
        @(negedge i_clk);
        i_awvalid = 0;
        i_wvalid = 0;
        i_arvalid = 0;
        wait_r(0, d, r);
        check("rw_same_rdata", d, old);
        wait_b(0, r);
        check("rw_same_bresp", r, OKAY);
        model_write(32'hC, 32'h7777_1111, 4'hF);
        check_regs();

        // Reset while only AW is held.
        i_awaddr = 32'h14;
        i_awvalid = 1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_arst_n = 0;
        i_awvalid = 0;
        model_reset();
        #1;
        check("mid_rst_bvalid", o_bvalid, 0);
        check("mid_rst_awready", o_awready, 0);
        check_regs();
        repeat (2) @(negedge i_clk);
        check("mid_rst_bvalid_hold", o_bvalid, 0);
        i_arst_n = 1;
        @(negedge i_clk);
        check("mid_rst_awready_back", o_awready, 1);
        check("mid_rst_bvalid_after", o_bvalid, 0);
        do_write(32'h14, 32'hCAFE_F00D, 4'hF, 0, 1, 0);
        do_read(32'h14, 0, 0);

`ifdef MY_AXI4_LITE_REG_SLV_WR_PULSE_EN
        pulse_write(32'hC, 32'h1357_9BDF, 8'b0000_1000);
        pulse_write(32'h0, 32'hFFFF_FFFF, 8'b0000_0000);
`endif

        for (int it = 0; it < 200; it++) begin
            a = ($urandom_range(7, 0) == 0) ? 32'(4 * N + $urandom_range(64, 0))
                                            : 32'($urandom_range(4 * N - 1, 0));
            if ($urandom_range(1, 0) == 1)
                do_write(a, $urandom, 4'($urandom_range(15, 0)), $urandom_range(3, 0),
                         $urandom_range(3, 0), $urandom_range(3, 0));
            else
                do_read(a, $urandom_range(2, 0), $urandom_range(3, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/my_axi4_lite_reg_slv.md
Name: my_axi4_lite_reg_slv

Overview:
- AXI4-Lite responder register file: the DUT-side end of the AXI4-Lite link that the UVM register-model bench drives as initiator.
- Holds N_REGS 32-bit word-aligned registers. Register 0 is a read-only ID; registers 1..N_REGS-1 are read/write with byte strobes.
- Register contents are exported flat to fabric logic. Sits between the bench/interconnect and the control/status logic.

Parameters:
- N_REGS, 8, number of 32-bit registers; power of 2, range 2..256.
- ID_VALUE, 32'h0001_0000, constant returned on reads of register 0.

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  reset, asynchronous, active-low
- i_awaddr  in  32  write address
- i_awprot  in  3  ignored
- i_awvalid  in  1  AW valid
- o_awready  out  1  AW ready
- i_wdata  in  32  write data
- i_wstrb  in  4  byte strobes
- i_wvalid  in  1  W valid
- o_wready  out  1  W ready
- o_bresp  out  2  write response (axi4_resp_t)
- o_bvalid  out  1  B valid
- i_bready  in  1  B ready
- i_araddr  in  32  read address
- i_arprot  in  3  ignored
- i_arvalid  in  1  AR valid
- o_arready  out  1  AR ready
- o_rdata  out  32  read data
- o_rresp  out  2  read response (axi4_resp_t)
- o_rvalid  out  1  R valid
- i_rready  in  1  R ready
- o_regs  out  32*N_REGS  register contents; reg k at bits [32k+31:32k]

Behaviour:
- Reset values (while i_arst_n low): all readies 0, o_bvalid/o_rvalid 0, o_rdata 0, o_bresp/o_rresp OKAY, registers 1..N-1 at 0.
- After reset: readies rise on the first clock edge after release.
- Address decode:
  - idx = addr[2 +: log2(N_REGS)]; addr[1:0] ignored.
  - addr >= 4*N_REGS gives DECERR.
  - Write to idx 0 gives SLVERR, no effect.
- Write path:
  - States: W_IDLE, W_COLLECT, W_RESP.
  - AW and W are accepted independently, in either order or the same cycle, each into a one-entry holding register.
  - o_awready = AW holder empty and not W_RESP; o_wready likewise for W.
  - The edge on which both holders are full (or fill on that edge) commits the write: bytes with wstrb=1 are updated, strobe 0 keeps the old byte.
  - That same edge sets o_bvalid/o_bresp and enters W_RESP, clearing the holders.
  - Commit latency: handshake at edge E0, register and B visible after E1.
  - o_bvalid and o_bresp are held stable until i_bready. The B handshake returns to W_IDLE and raises the readies.
- Read path:
  - States: R_IDLE, R_RESP. o_arready = R_IDLE.
  - AR handshake at E0: o_arready drops at E0; o_rvalid, o_rdata and o_rresp are registered at E1.
  - Data and response are held until i_rready; o_arready rises on the edge of the R handshake.
  - Error reads return o_rdata 0.
- Simultaneous read and write of the same register: the read returns the pre-write value if its data is sampled on the same edge as the commit.
- Outputs never change while valid is high and ready is low.
- Reset mid-transaction: the transaction is aborted, no response is issued, and all state returns to reset values.

Optional Feature:
- Macro: MY_AXI4_LITE_REG_SLV_WR_PULSE_EN.
- Defined: extra port o_wr_pulse, out, N_REGS bits. Bit idx is high for exactly one cycle after a successful (OKAY) commit to idx; it is also set on strobe-all-zero writes.
- Undefined: port and logic absent.

Decomposition:
- axi4_resp_t and the AXI4-Lite address/data widths (32/32) come from my_verif_params_pkg; the block imports it.
- Add to that package: the register word byte width (4) and the index-to-byte-offset shift (2).
- Natural sub-module: my_axi4_lite_reg_addr_dec. It is combinational (addr -> idx, resp) and is instantiated twice, once for AW and once for AR.

Test Plan:
- AW and W in the same cycle, addr 0x4, data 0xDEADBEEF, wstrb 0xF -> o_bvalid two edges later with OKAY; o_regs[63:32]=0xDEADBEEF; read 0x4 returns 0xDEADBEEF OKAY.
- W three cycles before AW (addr 0x8, data 0x12345678, wstrb 0x5) onto reg 0xFFFFFFFF -> reg becomes 0xFF34FF78, OKAY.
- Write 0x0 -> SLVERR and ID unchanged. Read 0x0 -> ID_VALUE. Read 0x20 with N_REGS=8 -> DECERR, rdata 0.
- Backpressure: hold i_bready and i_rready low for 5 cycles -> B and R signals stable; readies low; a second AW is not accepted until the B handshake.
- Assert i_arst_n low while holding AW only -> no B issued; after release, registers 0 and a fresh write completes normally.
- With MY_AXI4_LITE_REG_SLV_WR_PULSE_EN defined: write to 0xC -> o_wr_pulse=8'b0000_1000 for exactly 1 cycle. An erroring write produces no pulse.
